// File: rtl/stream_packer.sv
// Packs RATIO consecutive WIDTH-bit beats into one registered WIDTH*RATIO-bit word.
// Optional PACKER_LAST_EN adds s_last / m_keep / m_last for early flush of partial words.
module stream_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
`ifdef PACKER_LAST_EN
    input  logic                   s_last,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last,
`endif
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH*RATIO-1:0] m_data
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    logic [CW-1:0]              cnt;
    logic [WIDTH*(RATIO-1)-1:0] acc;
    logic [WIDTH*(RATIO-1)-1:0] acc_nxt;
    logic [WIDTH*RATIO-1:0]     full;
    logic [WIDTH*RATIO-1:0]     word;
    logic [RATIO-1:0]           keep_nxt;
    logic                       beat_last;
    logic                       in_acc;
    logic                       out_acc;
    logic                       complete;

`ifdef PACKER_LAST_EN
    assign beat_last = s_last;
`else
    assign beat_last = 1'b0;
`endif

    // A completing beat is only taken when the output register is free or draining.
    assign s_ready  = !m_valid || m_ready || ((cnt != CNT_MAX) && !beat_last);
    assign in_acc   = s_valid && s_ready;
    assign out_acc  = m_valid && m_ready;
    assign complete = in_acc && ((cnt == CNT_MAX) || beat_last);

    always_comb begin
        acc_nxt = acc;
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
            if (32'(cnt) == i) begin
                acc_nxt[i*WIDTH +: WIDTH] = s_data;
            end
        end
        full     = {s_data, acc_nxt};
        word     = '0;
        keep_nxt = '0;
        // Slots above cnt are explicitly zeroed so a flushed partial word is clean.
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i <= 32'(cnt)) begin
                keep_nxt[i]             = 1'b1;
                word[i*WIDTH +: WIDTH]  = full[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
`ifdef PACKER_LAST_EN
            m_keep  <= '0;
            m_last  <= 1'b0;
`endif
        end else if (complete) begin
            cnt     <= '0;
            acc     <= '0;
            m_valid <= 1'b1;
            m_data  <= word;
`ifdef PACKER_LAST_EN
            m_keep  <= keep_nxt;
            m_last  <= beat_last;
`endif
        end else begin
            if (in_acc) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end
            if (out_acc) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (WIDTH=8, RATIO=4).
// Covers the PACKER_LAST_EN flush path when that macro is defined.
module tb_stream_packer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
`ifdef PACKER_LAST_EN
    logic [3:0]  m_keep;
    logic        m_last;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    stream_packer #(
        .WIDTH(8),
        .RATIO(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef PACKER_LAST_EN
        .s_last  (s_last),
        .m_keep  (m_keep),
        .m_last  (m_last),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic mr);
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        s_last  = 1'b0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_word;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  m_data,       32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        #4 rst_n = 1'b1;
        tick();

        // Basic packing.
        drive(1'b1, 8'h11, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b1); tick();
        drive(1'b1, 8'h33, 1'b1); tick();
        chk("basic_no_early_valid", 32'(m_valid), 32'd0);
        drive(1'b1, 8'h44, 1'b1); tick();
        chk("basic_m_valid", 32'(m_valid), 32'd1);
        chk("basic_m_data",  m_data,       32'h44332211);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("basic_one_cycle", 32'(m_valid), 32'd0);

        // Back-to-back streaming with m_ready held high.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            #1;
            chk("stream_s_ready", 32'(s_ready), 32'd1);
            tick();
            if ((i % 4) == 3) begin
                exp_word = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                chk("stream_m_valid", 32'(m_valid), 32'd1);
                chk("stream_m_data",  m_data,       exp_word);
            end else begin
                chk("stream_m_valid_low", 32'(m_valid), 32'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("stream_drain", 32'(m_valid), 32'd0);

        // Backpressure: first word held, three more beats absorbed, completing beat stalled.
        drive(1'b1, 8'hA0, 1'b0); tick();
        drive(1'b1, 8'hA1, 1'b0); tick();
        drive(1'b1, 8'hA2, 1'b0); tick();
        drive(1'b1, 8'hA3, 1'b0); tick();
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data",  m_data,       32'hA3A2A1A0);
        for (int i = 4; i < 7; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
            #1;
            chk("bp_s_ready_partial", 32'(s_ready), 32'd1);
            tick();
            chk("bp_hold_data",  m_data,       32'hA3A2A1A0);
            chk("bp_hold_valid", 32'(m_valid), 32'd1);
        end
        drive(1'b1, 8'hA7, 1'b0);
        #1;
        chk("bp_s_ready_stall", 32'(s_ready), 32'd0);
        tick();
        chk("bp_stall_data",  m_data,       32'hA3A2A1A0);
        chk("bp_stall_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        #1;
        chk("bp_s_ready_release", 32'(s_ready), 32'd1);
        tick();
        chk("bp_b2b_valid", 32'(m_valid), 32'd1);
        chk("bp_b2b_data",  m_data,       32'hA7A6A5A4);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("bp_drain", 32'(m_valid), 32'd0);

        // Reset mid-group discards the partial beats.
        drive(1'b1, 8'h55, 1'b1); tick();
        drive(1'b1, 8'h66, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'h01, 1'b1); tick();
        drive(1'b1, 8'h02, 1'b1); tick();
        drive(1'b1, 8'h03, 1'b1); tick();
        chk("midrst_no_early_valid", 32'(m_valid), 32'd0);
        drive(1'b1, 8'h04, 1'b1); tick();
        chk("midrst_m_valid", 32'(m_valid), 32'd1);
        chk("midrst_m_data",  m_data,       32'h04030201);
        drive(1'b0, 8'h00, 1'b1); tick();

`ifdef PACKER_LAST_EN
        // Partial flush on s_last, then a full group.
        drive(1'b1, 8'hAA, 1'b1); tick();
        drive(1'b1, 8'hBB, 1'b1);
        s_last = 1'b1;
        tick();
        chk("last_m_valid", 32'(m_valid), 32'd1);
        chk("last_m_data",  m_data,       32'h0000BBAA);
        chk("last_m_keep",  32'(m_keep),  32'h3);
        chk("last_m_last",  32'(m_last),  32'd1);
        drive(1'b1, 8'hC0, 1'b1); tick();
        chk("last_cnt_reset", 32'(m_valid), 32'd0);
        drive(1'b1, 8'hC1, 1'b1); tick();
        drive(1'b1, 8'hC2, 1'b1); tick();
        drive(1'b1, 8'hC3, 1'b1); tick();
        chk("full_m_valid", 32'(m_valid), 32'd1);
        chk("full_m_data",  m_data,       32'hC3C2C1C0);
        chk("full_m_keep",  32'(m_keep),  32'hF);
        chk("full_m_last",  32'(m_last),  32'd0);
        drive(1'b0, 8'h00, 1'b1); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
